// File: rtl/data_mem.sv
// Byte-addressable data memory for the load/store path.
// One request per cycle, sub-word stores, extended loads, 1-cycle response.
module data_mem #(
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int IW = ADDR_W - 2;

   logic [31:0]   mem [DEPTH];

   logic          acc;
   logic          ill;
   logic          mis;
   logic          err;
   logic          we;
   logic [IW-1:0] idx;
   logic [1:0]    off;
   logic [3:0]    be;
   logic [31:0]   wrep;

   logic [31:0]   rd_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic          ld_q;

   logic [7:0]    bsel;
   logic [15:0]   hsel;
   logic [31:0]   ext;

   assign idx       = req_addr[ADDR_W-1:2];
   assign off       = req_addr[1:0];
   assign req_ready = rst_n && (!rsp_valid || rsp_ready);
   assign acc       = req_valid && req_ready;

   always_comb begin
      ill  = 1'b0;
      mis  = 1'b0;
      be   = 4'b0000;
      wrep = req_wdata;
      case (req_funct3)
         3'b000: begin
            be   = 4'b0001 << off;
            wrep = {4{req_wdata[7:0]}};
         end
         3'b001: begin
            mis  = off[0];
            be   = 4'b0011 << off;
            wrep = {2{req_wdata[15:0]}};
         end
         3'b010: begin
            mis  = |off;
            be   = 4'b1111;
         end
         3'b100, 3'b101: begin
            ill  = req_store;
            mis  = req_funct3[0] & off[0];
         end
         default: ill = 1'b1;
      endcase
   end

   assign err = ill | mis;
   assign we  = acc && req_store && !err;

   // Write commits at the accept edge so a following load sees it.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         ld_q      <= 1'b0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         rd_q      <= '0;
      end else if (acc) begin
         rsp_valid <= 1'b1;
         rsp_err   <= err;
         ld_q      <= !req_store && !err;
         f3_q      <= req_funct3;
         off_q     <= off;
         rd_q      <= mem[idx];
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   always_comb begin
      bsel = rd_q[7:0];
      case (off_q)
         2'd1:    bsel = rd_q[15:8];
         2'd2:    bsel = rd_q[23:16];
         2'd3:    bsel = rd_q[31:24];
         default: bsel = rd_q[7:0];
      endcase
      hsel = off_q[1] ? rd_q[31:16] : rd_q[15:0];
      ext  = '0;
      case (f3_q)
         3'b000:  ext = {{24{bsel[7]}}, bsel};
         3'b100:  ext = {24'h0, bsel};
         3'b001:  ext = {{16{hsel[15]}}, hsel};
         3'b101:  ext = {16'h0, hsel};
         3'b010:  ext = rd_q;
         default: ext = '0;
      endcase
      rsp_rdata = (rsp_valid && ld_q) ? ext : '0;
   end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: stores, extended loads, errors,
// back-pressure and asynchronous reset.
module tb_data_mem;

   localparam int AW = 14;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_store;
   logic [2:0]    req_funct3;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;

   int checks = 0;
   int errors = 0;

   data_mem #(.DEPTH(4096)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rq(input logic st, input logic [2:0] f3,
                     input logic [AW-1:0] a, input logic [31:0] d);
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_store = 1'b0;
   endtask

   task automatic rsp(input string tag, input logic [31:0] d,
                      input logic e);
      chk({tag, ".v"}, {31'h0, rsp_valid}, 32'h1);
      chk({tag, ".d"}, rsp_rdata, d);
      chk({tag, ".e"}, {31'h0, rsp_err}, {31'h0, e});
   endtask

   initial begin
      rst_n      = 1'b0;
      rsp_ready  = 1'b1;
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = '0;
      req_wdata  = '0;
      cyc();
      cyc();
      chk("rst.v", {31'h0, rsp_valid}, 32'h0);
      chk("rst.d", rsp_rdata, 32'h0);
      chk("rst.e", {31'h0, rsp_err}, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rst.rdy", {31'h0, req_ready}, 32'h1);

      // word store then load, back to back
      rq(1'b1, 3'b010, 14'h010, 32'hDEADBEEF);
      cyc();
      rsp("sw10", 32'h0, 1'b0);
      rq(1'b0, 3'b010, 14'h010, 32'h0);
      cyc();
      rsp("lw10", 32'hDEADBEEF, 1'b0);
      idle();
      cyc();
      chk("idle.v", {31'h0, rsp_valid}, 32'h0);

      // byte store and extension
      rq(1'b1, 3'b010, 14'h020, 32'h0);
      cyc();
      rq(1'b1, 3'b000, 14'h023, 32'h00000080);
      cyc();
      rq(1'b0, 3'b000, 14'h023, 32'h0);
      cyc();
      rsp("lb23", 32'hFFFFFF80, 1'b0);
      rq(1'b0, 3'b100, 14'h023, 32'h0);
      cyc();
      rsp("lbu23", 32'h00000080, 1'b0);
      rq(1'b0, 3'b010, 14'h020, 32'h0);
      cyc();
      rsp("lw20", 32'h80000000, 1'b0);

      // halfword store and extension
      rq(1'b1, 3'b010, 14'h030, 32'h11223344);
      cyc();
      rq(1'b1, 3'b001, 14'h032, 32'h00008001);
      cyc();
      rq(1'b0, 3'b010, 14'h030, 32'h0);
      cyc();
      rsp("lw30", 32'h80013344, 1'b0);
      rq(1'b0, 3'b001, 14'h032, 32'h0);
      cyc();
      rsp("lh32", 32'hFFFF8001, 1'b0);
      rq(1'b0, 3'b101, 14'h032, 32'h0);
      cyc();
      rsp("lhu32", 32'h00008001, 1'b0);

      // error cases
      rq(1'b1, 3'b010, 14'h040, 32'hCAFEF00D);
      cyc();
      rq(1'b0, 3'b010, 14'h041, 32'h0);
      cyc();
      rsp("lw41", 32'h0, 1'b1);
      rq(1'b1, 3'b001, 14'h043, 32'h0000BEEF);
      cyc();
      rsp("sh43", 32'h0, 1'b1);
      rq(1'b1, 3'b100, 14'h040, 32'h00000011);
      cyc();
      rsp("sbu40", 32'h0, 1'b1);
      rq(1'b0, 3'b111, 14'h040, 32'h0);
      cyc();
      rsp("f3_7", 32'h0, 1'b1);
      rq(1'b0, 3'b010, 14'h040, 32'h0);
      cyc();
      rsp("lw40", 32'hCAFEF00D, 1'b0);

      // back-pressure
      idle();
      cyc();
      rsp_ready = 1'b0;
      rq(1'b0, 3'b010, 14'h010, 32'h0);
      cyc();
      rsp("bp0", 32'hDEADBEEF, 1'b0);
      rq(1'b0, 3'b010, 14'h020, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         rsp("bp.hold", 32'hDEADBEEF, 1'b0);
         chk("bp.rdy", {31'h0, req_ready}, 32'h0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp.rdy1", {31'h0, req_ready}, 32'h1);
      cyc();
      rsp("bp1", 32'h80000000, 1'b0);
      idle();
      cyc();
      chk("bp.one", {31'h0, rsp_valid}, 32'h0);

      // asynchronous reset while a store response is held
      rsp_ready = 1'b0;
      rq(1'b1, 3'b010, 14'h100, 32'h12345678);
      cyc();
      rsp("sw100", 32'h0, 1'b0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.v", {31'h0, rsp_valid}, 32'h0);
      chk("ar.d", rsp_rdata, 32'h0);
      chk("ar.e", {31'h0, rsp_err}, 32'h0);
      cyc();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      rq(1'b0, 3'b010, 14'h100, 32'h0);
      cyc();
      rsp("lw100", 32'h12345678, 1'b0);
      idle();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
